// File: rtl/prng_arbiter_pkg.sv
// prng_arbiter_pkg: PRNG widths shared with seed_expander/Trivium wrapper and the arbiter state encoding
package prng_arbiter_pkg;
  localparam int PRNG_NUM_REQ = 2;
  localparam int PRNG_SEED_W = 256;
  localparam int PRNG_DATA_W = 128;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;
  // width of a client index, at least one bit so a single client still has a pointer
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/prng_arbiter_rr_pick.sv
// prng_arbiter_rr_pick: combinational round-robin picker, first request at or after ptr_i
module prng_arbiter_rr_pick
  import prng_arbiter_pkg::*;
#(
  parameter int NUM_REQ = PRNG_NUM_REQ,
  localparam int PW = ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PW-1:0]      idx_o
);
  logic [2*NUM_REQ-1:0] rot_dbl, gnt_dbl;
  logic [NUM_REQ-1:0] rot, first;
  // rotate ptr_i down to bit 0, keep the lowest set bit, rotate it back
  always_comb begin
    rot_dbl = {req_i, req_i} >> ptr_i;
    rot = rot_dbl[NUM_REQ-1:0];
    first = rot & (-rot);
    gnt_dbl = {first, first} << ptr_i;
    gnt_o = gnt_dbl[2*NUM_REQ-1:NUM_REQ];
  end
  // binary index of the chosen client
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NUM_REQ; i++) idx_o = gnt_o[i] ? PW'(i) : idx_o;
  end
endmodule

// File: rtl/prng_arbiter.sv
// prng_arbiter: round-robin, session-locked sharing of one Trivium PRNG among NUM_REQ clients
module prng_arbiter
  import prng_arbiter_pkg::*;
#(
  parameter int NUM_REQ = PRNG_NUM_REQ,
  parameter int SEED_W  = PRNG_SEED_W,
  parameter int DATA_W  = PRNG_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic [NUM_REQ*SEED_W-1:0] c_seed,
  input  logic [NUM_REQ-1:0]        c_reseed,
  output logic [NUM_REQ-1:0]        c_reseed_ack,
  input  logic [NUM_REQ-1:0]        c_rdi_ready,
  output logic [NUM_REQ-1:0]        c_rdi_valid,
  output logic [DATA_W-1:0]         c_rdi_data,
  output logic [SEED_W-1:0]         seed,
  output logic                      reseed,
  input  logic                      reseed_ack,
  output logic                      rdi_ready,
  input  logic                      rdi_valid,
  input  logic [DATA_W-1:0]         rdi_data,
  output logic                      busy
);
  localparam int PW = ptr_w(NUM_REQ);
  arb_state_e state_q;
  logic [NUM_REQ-1:0] gnt_q, pick;
  logic [PW-1:0] rr_ptr_q, owner_q, pick_idx, next_ptr;
  logic pend_rdi_q, pend_rdi_d, pend_rs_q, pend_rs_d, owner_req, fwd_en;
  prng_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick),
    .idx_o (pick_idx)
  );
  assign gnt = gnt_q;
  assign busy = state_q != ST_IDLE;
  assign c_reseed_ack = gnt_q & {NUM_REQ{reseed_ack}};
  assign c_rdi_valid = gnt_q & {NUM_REQ{rdi_valid}};
  assign c_rdi_data = (|gnt_q) ? rdi_data : '0;
  assign next_ptr = (owner_q == PW'(NUM_REQ-1)) ? '0 : owner_q + PW'(1);
  // owner's seed always visible; new handshakes only open while BUSY, never in DRAIN
  always_comb begin
    seed = '0;
    for (int i = 0; i < NUM_REQ; i++) seed = gnt_q[i] ? c_seed[i*SEED_W +: SEED_W] : seed;
    fwd_en = state_q == ST_BUSY;
    owner_req = |(req & gnt_q);
    reseed = fwd_en & |(c_reseed & gnt_q);
    rdi_ready = fwd_en & |(c_rdi_ready & gnt_q);
  end
  // in-flight tracking; a response in the same cycle as its request leaves nothing pending
  always_comb begin
    pend_rdi_d = rdi_valid ? 1'b0 : (rdi_ready | pend_rdi_q);
    pend_rs_d = reseed_ack ? 1'b0 : (reseed | pend_rs_q);
  end
  // session FSM: grant on IDLE, end on owner release, drain outstanding handshakes first
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q <= '0;
      owner_q <= '0;
      rr_ptr_q <= '0;
      pend_rdi_q <= 1'b0;
      pend_rs_q <= 1'b0;
    end else begin
      pend_rdi_q <= pend_rdi_d;
      pend_rs_q <= pend_rs_d;
      if (state_q == ST_IDLE) begin
        if (|req) begin
          state_q <= ST_BUSY;
          gnt_q <= pick;
          owner_q <= pick_idx;
        end
      end else if (state_q == ST_BUSY && !owner_req && (pend_rdi_d || pend_rs_d)) begin
        state_q <= ST_DRAIN;
      end else if ((state_q != ST_BUSY || !owner_req) && !pend_rdi_d && !pend_rs_d) begin
        state_q <= ST_IDLE;
        gnt_q <= '0;
        rr_ptr_q <= next_ptr;
      end
    end
  end
endmodule

// File: tb/tb_prng_arbiter.sv
// tb_prng_arbiter: scenario tasks with an rdi routing scoreboard for prng_arbiter
module tb_prng_arbiter;
  localparam int N = 2;
  localparam int SW = 256;
  localparam int DW = 128;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0, c_reseed = '0, c_rdi_ready = '0;
  logic [N-1:0] gnt, c_reseed_ack, c_rdi_valid;
  logic [N*SW-1:0] c_seed = '0;
  logic [DW-1:0] c_rdi_data;
  logic [DW-1:0] rdi_data = '0;
  logic [SW-1:0] seed;
  logic reseed, rdi_ready, busy;
  logic reseed_ack = 1'b0, rdi_valid = 1'b0;
  typedef struct {
    logic [N-1:0]  vld;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, stored = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  prng_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .c_seed(c_seed), .c_reseed(c_reseed),
    .c_reseed_ack(c_reseed_ack), .c_rdi_ready(c_rdi_ready), .c_rdi_valid(c_rdi_valid),
    .c_rdi_data(c_rdi_data), .seed(seed), .reseed(reseed), .reseed_ack(reseed_ack),
    .rdi_ready(rdi_ready), .rdi_valid(rdi_valid), .rdi_data(rdi_data), .busy(busy)
  );

  // scoreboard: every routed rdi word must match the oldest expected owner/data
  always @(negedge clk) begin
    if (mon_en && c_rdi_valid !== '0) begin
      exp_t e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rdi_route: c_rdi_valid=%b while nothing expected", c_rdi_valid);
      end else begin
        e = sb.pop_front();
        if (c_rdi_valid !== e.vld || c_rdi_data !== e.data) begin
          bad++;
          $display("FAIL rdi_route: valid=%b data=%h, want valid=%b data=%h", c_rdi_valid, c_rdi_data, e.vld, e.data);
        end
      end
      if (c_rdi_valid[1] === 1'b1) stored++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rdi(input logic [N-1:0] who);
    exp_t e;
    rdi_valid = 1'b1;
    rdi_data = {$urandom, $urandom, $urandom, $urandom};
    e.vld = who;
    e.data = rdi_data;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; c_reseed = '1; c_rdi_ready = '1;
    reseed_ack = 1'b1; rdi_valid = 1'b1; rdi_data = '1;
    c_seed = {16{$urandom, $urandom}};
    tick; tick;
    @(negedge clk);
    total++;
    if ({gnt, busy, reseed, rdi_ready, c_reseed_ack, c_rdi_valid} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: gnt=%b busy=%b reseed=%b rdi_ready=%b ack=%b valid=%b, want all 0", gnt, busy, reseed, rdi_ready, c_reseed_ack, c_rdi_valid);
    end
    total++;
    if (seed !== '0 || c_rdi_data !== '0) begin
      bad++;
      $display("FAIL reset_data: seed=%h rdi_data=%h, want 0", seed, c_rdi_data);
    end
    rst = 1'b0; req = '0; c_reseed = '0; c_rdi_ready = '0;
    reseed_ack = 1'b0; rdi_valid = 1'b0; rdi_data = '0;
    tick;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    logic [SW-1:0] sd;
    sd = {32{8'hA5}};
    req = 2'b01;
    tick;
    @(negedge clk);
    total++;
    if (gnt !== 2'b01 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_gnt: gnt=%b busy=%b, want 01 1", gnt, busy);
    end
    tick;
    c_seed[0 +: SW] = sd; c_seed[SW +: SW] = ~sd; c_reseed = 2'b01;
    @(negedge clk);
    total++;
    if (reseed !== 1'b1 || seed !== sd) begin
      bad++;
      $display("FAIL single_seed: reseed=%b seed=%h, want 1 %h", reseed, seed, sd);
    end
    tick; tick;
    reseed_ack = 1'b1;
    @(negedge clk);
    total++;
    if (c_reseed_ack !== 2'b01) begin
      bad++;
      $display("FAIL single_ack: c_reseed_ack=%b, want 01", c_reseed_ack);
    end
    tick;
    reseed_ack = 1'b0; c_reseed = '0;
    @(negedge clk);
    total++;
    if (c_reseed_ack !== 2'b00 || reseed !== 1'b0) begin
      bad++;
      $display("FAIL single_ack_pulse: c_reseed_ack=%b reseed=%b, want 00 0", c_reseed_ack, reseed);
    end
    tick;
    req = '0;
    tick;
    @(negedge clk);
    total++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_end: gnt=%b busy=%b, want 00 0", gnt, busy);
    end
  endtask

  task automatic test_contention();
    rst = 1'b1;
    tick;
    rst = 1'b0; req = 2'b11;
    tick;
    @(negedge clk);
    total++;
    if (gnt !== 2'b01) begin
      bad++;
      $display("FAIL cont_first: gnt=%b, want 01", gnt);
    end
    tick;
    req = 2'b10;
    tick;
    @(negedge clk);
    total++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL cont_gap: gnt=%b busy=%b, want 00 0", gnt, busy);
    end
    tick;
    @(negedge clk);
    total++;
    if (gnt !== 2'b10) begin
      bad++;
      $display("FAIL cont_second: gnt=%b, want 10", gnt);
    end
    tick;
    req = 2'b11;
    @(negedge clk);
    total++;
    if (gnt !== 2'b10) begin
      bad++;
      $display("FAIL cont_nopreempt: gnt=%b, want 10", gnt);
    end
    tick;
    req = 2'b01;
    tick;
    @(negedge clk);
    total++;
    if (gnt !== 2'b00) begin
      bad++;
      $display("FAIL cont_gap2: gnt=%b, want 00", gnt);
    end
    tick;
    @(negedge clk);
    total++;
    if (gnt !== 2'b01) begin
      bad++;
      $display("FAIL cont_rr: gnt=%b, want 01", gnt);
    end
    tick;
    req = '0;
    tick;
  endtask

  task automatic test_drain();
    req = 2'b01;
    tick;
    @(negedge clk);
    total++;
    if (gnt !== 2'b01) begin
      bad++;
      $display("FAIL drain_gnt: gnt=%b, want 01", gnt);
    end
    tick;
    c_rdi_ready = 2'b01;
    @(negedge clk);
    total++;
    if (rdi_ready !== 1'b1) begin
      bad++;
      $display("FAIL drain_ready: rdi_ready=%b, want 1", rdi_ready);
    end
    tick;
    c_rdi_ready = '0; req = 2'b10;
    tick;
    c_rdi_ready = 2'b11; c_reseed = 2'b11;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || gnt !== 2'b01 || rdi_ready !== 1'b0 || reseed !== 1'b0) begin
      bad++;
      $display("FAIL drain_hold: busy=%b gnt=%b rdi_ready=%b reseed=%b, want 1 01 0 0", busy, gnt, rdi_ready, reseed);
    end
    tick; tick;
    @(negedge clk);
    total++;
    if (gnt !== 2'b01 || busy !== 1'b1) begin
      bad++;
      $display("FAIL drain_wait: gnt=%b busy=%b, want 01 1", gnt, busy);
    end
    tick;
    c_rdi_ready = '0; c_reseed = '0;
    send_rdi(2'b01);
    tick;
    rdi_valid = 1'b0;
    @(negedge clk);
    total++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL drain_idle: gnt=%b busy=%b, want 00 0", gnt, busy);
    end
    tick;
    @(negedge clk);
    total++;
    if (gnt !== 2'b10) begin
      bad++;
      $display("FAIL drain_regrant: gnt=%b, want 10", gnt);
    end
    tick;
    req = '0;
    tick;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_sb: %0d rdi words undelivered, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_isolation();
    logic [SW-1:0] s0, s1;
    s0 = {8{$urandom}}; s1 = {8{$urandom}} ^ {SW{1'b1}};
    c_seed = {s1, s0}; req = 2'b10;
    tick;
    @(negedge clk);
    total++;
    if (gnt !== 2'b10 || seed !== s1) begin
      bad++;
      $display("FAIL iso_gnt: gnt=%b seed=%h, want 10 %h", gnt, seed, s1);
    end
    for (int k = 0; k < 4; k++) begin
      tick;
      req = 2'b11; c_reseed = {1'b0, k[0]}; c_rdi_ready = {1'b0, ~k[0]};
      @(negedge clk);
      total++;
      if (reseed !== 1'b0 || rdi_ready !== 1'b0 || seed !== s1) begin
        bad++;
        $display("FAIL iso_block%0d: reseed=%b rdi_ready=%b, want 0 0", k, reseed, rdi_ready);
      end
    end
    tick;
    c_reseed = '0; c_rdi_ready = 2'b01;
    send_rdi(2'b10);
    tick;
    c_rdi_ready = 2'b10;
    send_rdi(2'b10);
    @(negedge clk);
    total++;
    if (rdi_ready !== 1'b1) begin
      bad++;
      $display("FAIL iso_owner_ready: rdi_ready=%b, want 1", rdi_ready);
    end
    tick;
    c_rdi_ready = '0; rdi_valid = 1'b0; req = '0;
    tick;
    @(negedge clk);
    total++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL iso_end: gnt=%b busy=%b, want 00 0", gnt, busy);
    end
    tick;
    rdi_valid = 1'b1; reseed_ack = 1'b1;
    @(negedge clk);
    total++;
    if (c_rdi_valid !== 2'b00 || c_reseed_ack !== 2'b00) begin
      bad++;
      $display("FAIL iso_stray: c_rdi_valid=%b c_reseed_ack=%b, want 00 00", c_rdi_valid, c_reseed_ack);
    end
    tick;
    rdi_valid = 1'b0; reseed_ack = 1'b0;
    tick;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL iso_sb: %0d rdi words undelivered, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_busy();
    req = 2'b01;
    tick; tick;
    c_rdi_ready = 2'b01;
    tick;
    c_rdi_ready = '0; c_reseed = 2'b01; rst = 1'b1;
    tick;
    rdi_valid = 1'b1; reseed_ack = 1'b1; c_rdi_ready = 2'b01;
    @(negedge clk);
    total++;
    if ({gnt, busy, reseed, rdi_ready, c_reseed_ack, c_rdi_valid} !== '0 || c_rdi_data !== '0 || seed !== '0) begin
      bad++;
      $display("FAIL rstbusy_out: gnt=%b busy=%b reseed=%b rdi_ready=%b ack=%b valid=%b, want all 0", gnt, busy, reseed, rdi_ready, c_reseed_ack, c_rdi_valid);
    end
    tick;
    rst = 1'b0; rdi_valid = 1'b0; reseed_ack = 1'b0; c_rdi_ready = '0; c_reseed = '0;
    tick;
    @(negedge clk);
    total++;
    if (gnt !== 2'b01) begin
      bad++;
      $display("FAIL rstbusy_regrant: gnt=%b, want 01", gnt);
    end
    tick;
    req = '0;
    tick;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rstbusy_pend: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_session();
    logic [SW-1:0] s;
    for (int w = 0; w < 8; w++) s[w*32 +: 32] = $urandom;
    stored = 0;
    c_seed[SW +: SW] = s; c_seed[0 +: SW] = ~s; req = 2'b10;
    tick;
    @(negedge clk);
    total++;
    if (gnt !== 2'b10) begin
      bad++;
      $display("FAIL sess_gnt: gnt=%b, want 10", gnt);
    end
    tick;
    c_reseed = 2'b10;
    @(negedge clk);
    total++;
    if (reseed !== 1'b1 || seed !== s) begin
      bad++;
      $display("FAIL sess_seed: reseed=%b seed=%h, want 1 %h", reseed, seed, s);
    end
    tick; tick;
    reseed_ack = 1'b1;
    tick;
    reseed_ack = 1'b0; c_reseed = '0;
    for (int k = 0; k < 4; k++) begin
      tick;
      rdi_valid = 1'b0; c_rdi_ready = 2'b10;
      @(negedge clk);
      total++;
      if (rdi_ready !== 1'b1) begin
        bad++;
        $display("FAIL sess_pull%0d: rdi_ready=%b, want 1", k, rdi_ready);
      end
      tick;
      c_rdi_ready = '0;
      send_rdi(2'b10);
    end
    tick;
    rdi_valid = 1'b0; req = '0;
    tick;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || stored !== 4) begin
      bad++;
      $display("FAIL sess_done: busy=%b stored=%0d, want 0 4", busy, stored);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sess_sb: %0d rdi words undelivered, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_drain();
    test_isolation();
    test_reset_busy();
    test_session();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
